// File: rtl/gf_mac_unit.sv
// rtl/gf_mac_unit.sv - GF(2^M) multiply / square / multiply-accumulate / inverse unit
// One request at a time: IDLE accepts, CALC iterates, DONE holds the result until taken.
module gf_mac_unit #(
    parameter int         M    = 8,
    parameter logic [M:0] POLY = 9'h11D
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic         acc_clr,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_data,
    output logic         out_err
);

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_SQR = 2'b01;
    localparam logic [1:0] OP_MAC = 2'b10;
    localparam logic [1:0] OP_INV = 2'b11;
    localparam logic [4:0] LAST_STEP = 5'(M - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [1:0]     r_op;
    logic           r_acc_clr;
    logic [M-1:0]   r_a;
    logic [M-1:0]   r_b;
    logic [M-1:0]   r_r;
    logic [M-1:0]   r_acc;
    logic [M-1:0]   r_out_data;
    logic           r_out_err;
    logic [4:0]     r_step;

    logic [M-1:0]   w_ab;
    logic [M-1:0]   w_sq;
    logic [M-1:0]   w_sq_a;
    logic [M-1:0]   w_mac;
    logic           w_inv_last;

    // MSB-first shift-and-add; each shift reduces by POLY before the next partial product.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
        logic [M-1:0] p;
        p = '0;
        for (int i = M - 1; i >= 0; i--) begin
            p = {p[M-2:0], 1'b0} ^ ({M{p[M-1]}} & POLY[M-1:0]) ^ ({M{y[i]}} & x);
        end
        return p;
    endfunction

    assign w_ab       = gf_mul(r_a, (r_op == OP_SQR) ? r_a : r_b);
    assign w_sq       = gf_mul(r_r, r_r);
    assign w_sq_a     = gf_mul(w_sq, r_a);
    assign w_mac      = r_acc_clr ? w_ab : (r_acc ^ w_ab);
    assign w_inv_last = (r_step == LAST_STEP);

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_state_nxt = S_CALC;
            S_CALC: if (r_op != OP_INV || w_inv_last) w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= OP_MUL;
            r_acc_clr  <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_r        <= '0;
            r_acc      <= '0;
            r_out_data <= '0;
            r_out_err  <= 1'b0;
            r_step     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op      <= op;
                        r_acc_clr <= acc_clr;
                        r_a       <= a;
                        r_b       <= b;
                        r_r       <= a;
                        r_step    <= '0;
                    end
                end
                S_CALC: begin
                    if (r_op == OP_INV) begin
                        // r holds a^(2^(k+1)-1) after k steps; the last step only squares.
                        if (w_inv_last) begin
                            r_out_data <= w_sq;
                            r_out_err  <= (r_a == '0);
                        end else begin
                            r_r    <= w_sq_a;
                            r_step <= r_step + 5'd1;
                        end
                    end else if (r_op == OP_MAC) begin
                        r_acc      <= w_mac;
                        r_out_data <= w_mac;
                        r_out_err  <= 1'b0;
                    end else begin
                        r_out_data <= w_ab;
                        r_out_err  <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_data <= '0;
                        r_out_err  <= 1'b0;
                        r_step     <= '0;
                    end
                end
                default: begin
                    r_step <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf_mac_unit.sv
// tb/tb_gf_mac_unit.sv - scoreboard bench for gf_mac_unit at M=8, POLY=0x11D
module tb_gf_mac_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op;
    logic       acc_clr;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] acc_m = 8'h00;

    always #5 clk = ~clk;

    gf_mac_unit #(.M(8), .POLY(9'h11D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .acc_clr   (acc_clr),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // LSB-first multiply with xtime, a different formulation from the unit's.
    function automatic logic [7:0] m_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p = 8'h00;
        logic [7:0] s = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ s;
            s = s[7] ? ({s[6:0], 1'b0} ^ 8'h1D) : {s[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] m_inv(input logic [7:0] x);
        for (int c = 1; c < 256; c++) begin
            if (m_mul(x, 8'(c)) == 8'h01) return 8'(c);
        end
        return 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] o, input logic clr, input logic [7:0] va,
                          input logic [7:0] vb, input int stall);
        exp_t       e;
        int         lat;
        logic       zero_ok;
        logic [7:0] held;
        e.err = 1'b0;
        e.lat = (o == 2'b11) ? 7 : 1;
        case (o)
            2'b00: e.data = m_mul(va, vb);
            2'b01: e.data = m_mul(va, va);
            2'b10: begin
                acc_m  = clr ? m_mul(va, vb) : (acc_m ^ m_mul(va, vb));
                e.data = acc_m;
            end
            default: begin
                e.data = m_inv(va);
                e.err  = (va == 8'h00);
            end
        endcase
        sb.push_back(e);

        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = o; acc_clr = clr; a = va; b = vb;
        tick();
        in_valid = 1'b0; a = $urandom; b = $urandom; acc_clr = $urandom;

        lat = 0;
        zero_ok = 1'b1;
        while (!out_valid && lat < 64) begin
            if (out_data !== 8'h00 || out_err !== 1'b0) zero_ok = 1'b0;
            tick();
            lat++;
        end
        e = sb.pop_front();
        check("latency", 32'(lat), 32'(e.lat));
        check("idle_outputs_zero", 32'(zero_ok), 32'd1);
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_err", 32'(out_err), 32'(e.err));
        held = out_data;

        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
            tick();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(held));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("handoff_valid", 32'(out_valid), 32'd0);
        check("handoff_in_ready", 32'(in_ready), 32'd1);
        check("handoff_data_zero", 32'(out_data), 32'd0);
    endtask

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; op = 2'b00; acc_clr = 1'b0;
        a = 8'h00; b = 8'h00; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);

        run_op(2'b00, 1'b0, 8'h02, 8'h80, 0);
        check("mul_02_80_const", 32'(acc_m), 32'h00);
        run_op(2'b00, 1'b0, 8'h02, 8'h02, 0);
        run_op(2'b01, 1'b0, 8'h80, 8'hFF, 0);
        run_op(2'b10, 1'b1, 8'h02, 8'h02, 0);
        check("mac_clr_acc", 32'(acc_m), 32'h04);
        run_op(2'b10, 1'b0, 8'h02, 8'h80, 0);
        check("mac_acc_19", 32'(acc_m), 32'h19);
        run_op(2'b00, 1'b1, 8'h01, 8'h01, 0);
        run_op(2'b10, 1'b0, 8'h00, 8'h00, 5);
        run_op(2'b11, 1'b0, 8'h02, 8'h00, 0);
        run_op(2'b11, 1'b0, 8'h00, 8'h00, 2);
        run_op(2'b11, 1'b0, 8'h01, 8'h00, 0);

        // Abort an inverse mid-iteration; acc must come back cleared.
        in_valid = 1'b1; op = 2'b11; a = 8'h53; b = 8'h00;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        acc_m = 8'h00;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_data", 32'(out_data), 32'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        run_op(2'b00, 1'b0, 8'h02, 8'h80, 0);
        run_op(2'b10, 1'b0, 8'h01, 8'h01, 0);

        for (int i = 0; i < 30; i++) begin
            run_op(2'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 2)));
        end
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gf_mac_unit.md
GF_MAC_UNIT -- requirements
Module: gf_mac_unit

Interface
REQ-001 SHALL have parameter M, default 8: field degree, GF(2^M) elements are M bits wide; legal range 3..16.
REQ-002 SHALL have parameter POLY, default 9'h11D, width M+1: field generator polynomial; bit M SHALL be 1.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: operand/op request valid.
REQ-006 SHALL have port in_ready, output, 1: unit can accept a request.
REQ-007 SHALL have port op, input, 2: operation; 00 MUL, 01 SQR, 10 MAC, 11 INV.
REQ-008 SHALL have port acc_clr, input, 1: with MAC, load accumulator instead of accumulate.
REQ-009 SHALL have port a, input, M: first operand.
REQ-010 SHALL have port b, input, M: second operand (MUL/MAC only).
REQ-011 SHALL have port out_valid, output, 1: result valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-013 SHALL have port out_data, output, M: result.
REQ-014 SHALL have port out_err, output, 1: qualified by out_valid; 1 only for INV of zero.

Function
REQ-015 SHALL implement GF(2^M) product as polynomial multiply over GF(2) reduced modulo POLY, for any legal M/POLY.
REQ-016 SHALL use states IDLE, CALC, DONE; in_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge with in_valid=1 and in_ready=1, latching op, acc_clr, a, b; IDLE->CALC.
REQ-018 SHALL treat in_valid while in_ready=0 as not accepted; inputs ignored, no queuing.
REQ-019 MUL SHALL yield a*b; SQR SHALL yield a*a with b ignored.
REQ-020 MAC SHALL update internal M-bit accumulator acc <= acc ^ (a*b), or acc <= a*b when acc_clr=1; out_data = updated acc.
REQ-021 SHALL leave acc unchanged by MUL, SQR, INV; acc_clr SHALL be ignored for non-MAC ops.
REQ-022 INV SHALL compute a^(2^M-2) by square-and-multiply: r=a at accept; M-2 CALC cycles of r=r*r*a; one final cycle of r=r*r.
REQ-023 CALC duration SHALL be 1 cycle for MUL/SQR/MAC and M-1 cycles for INV, counted by an internal step counter.
REQ-024 out_valid SHALL rise in the cycle after the last CALC cycle (L = 1 or M-1 cycles after the accept edge); state DONE.
REQ-025 In DONE, out_valid, out_data, out_err SHALL stay stable until an edge with out_ready=1; then DONE->IDLE.
REQ-026 SHALL allow the next accept no earlier than the cycle after result handoff (in_ready rises the cycle after out_ready accept).
REQ-027 INV of a=0 SHALL give out_data=0, out_err=1; every other result SHALL give out_err=0.
REQ-028 out_data and out_err SHALL be 0 whenever out_valid=0.

Reset
REQ-029 On rst=1 at a clock edge: state IDLE, acc=0, step counter=0, out_valid=0, out_data=0, out_err=0, in_ready=1 the following cycle.
REQ-030 rst SHALL override any in-flight operation (CALC or DONE); aborted result never presented, acc not updated by it.
REQ-031 rst SHALL take priority over simultaneous in_valid/out_ready.

Verification (M=8, POLY=9'h11D)
REQ-032 MUL a=0x02,b=0x80 -> out_valid 1 cycle after accept, out_data=0x1D, out_err=0; MUL 0x02*0x02 -> 0x04.
REQ-033 SQR a=0x80, b=0xFF -> out_data=0x13.
REQ-034 MAC acc_clr=1 a=0x02,b=0x02 -> 0x04; then MAC acc_clr=0 a=0x02,b=0x80 -> 0x19; then MUL 0x01*0x01 -> 0x01, then MAC 0x00*0x00 -> 0x19 (acc untouched by MUL).
REQ-035 INV a=0x02 -> out_valid exactly 7 cycles after accept, out_data=0x8E; INV a=0x00 -> out_data=0x00, out_err=1; INV a=0x01 -> 0x01.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles after result -> out_valid/out_data stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-037 Assert rst during INV CALC step 3 -> next cycle IDLE, out_valid=0, acc=0; subsequent MUL 0x02*0x80 -> 0x1D.
